// File: rtl/chu_vga_pkg.sv
// Shared types and register map for the VGA overlay/fade slot; no logic, no latency.
// Status word layout: [FW:0] alpha level, [8] busy, [9] done.
package chu_vga_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_WIN    = 2'd1,
    MODE_KEY    = 2'd2,
    MODE_RSV    = 2'd3
  } mode_t;

  typedef enum logic {
    FADE_IDLE = 1'b0,
    FADE_RUN  = 1'b1
  } fade_state_t;

  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_XWIN = 3'd1;
  localparam logic [2:0] REG_YWIN = 3'd2;
  localparam logic [2:0] REG_KEY  = 3'd3;
  localparam logic [2:0] REG_FPS  = 3'd4;

  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_DIR_BIT   = 3;
  localparam int ST_BUSY_BIT    = 8;
  localparam int ST_DONE_BIT    = 9;

  // A programmed frame count of zero behaves as one frame per step.
  function automatic logic [7:0] fps_eff(input logic [7:0] fps);
    return (fps == 8'd0) ? 8'd1 : fps;
  endfunction

endpackage

// File: rtl/vga_fade_ctrl.sv
// Frame-stepped alpha ramp: level moves one step every fps frame starts; state updates on fs.
// No backpressure; start is only ever presented together with fs.
module vga_fade_ctrl
  import chu_vga_pkg::*;
#(
  parameter int FW = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fs,
  input  logic        start,
  input  logic        dir,
  input  logic [7:0]  fps,
  output logic [FW:0] level,
  output logic        busy,
  output logic        done
);

  localparam logic [FW:0] L_MAX = (FW+1)'(2**FW);
  localparam logic [FW:0] L_ONE = (FW+1)'(1);

  fade_state_t state_q, state_d;
  logic [FW:0] lvl_q, lvl_d;
  logic [7:0]  div_q, div_d;
  logic        dir_q, dir_d;
  logic        done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FADE_IDLE;
      lvl_q   <= L_MAX;
      div_q   <= 8'd1;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      div_q   <= div_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    div_d   = div_q;
    dir_d   = dir_q;
    done_d  = done_q;
    if (start) begin
      // Restart from the start level even if a fade is already running.
      state_d = FADE_RUN;
      dir_d   = dir;
      lvl_d   = dir ? L_MAX : '0;
      div_d   = fps_eff(fps);
      done_d  = 1'b0;
    end else if (fs && state_q == FADE_RUN) begin
      if (div_q <= 8'd1) begin
        div_d = fps_eff(fps);
        lvl_d = dir_q ? (lvl_q - L_ONE) : (lvl_q + L_ONE);
        if (dir_q ? (lvl_q == L_ONE) : (lvl_q == L_MAX - L_ONE)) begin
          state_d = FADE_IDLE;
          done_d  = 1'b1;
        end
      end else begin
        div_d = div_q - 8'd1;
      end
    end
  end

  assign level = lvl_q;
  assign busy  = (state_q == FADE_RUN);
  assign done  = done_q;

endmodule

// File: rtl/chu_vga_fade_core.sv
// Window/colour-key overlay with alpha blend; so_rgb registered (1 clk), no backpressure.
// VGA_FADE_EN builds the fade engine; without it alpha is fixed fully opaque.
module chu_vga_fade_core
  import chu_vga_pkg::*;
#(
  parameter int CD = 12,
  parameter int FW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [CD-1:0] si_rgb,
  input  logic [CD-1:0] ovl_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam int          CW    = CD / 3;
  localparam int          AW    = CW + FW + 1;
  localparam logic [FW:0] L_MAX = (FW+1)'(2**FW);

  logic          we, at_origin, origin_q, fs;
  mode_t         stg_mode, act_mode;
  logic [10:0]   stg_x0, stg_x1, stg_y0, stg_y1;
  logic [10:0]   act_x0, act_x1, act_y0, act_y1;
  logic [CD-1:0] stg_key, act_key;
  logic [FW:0]   lvl, inv_lvl;
  logic          busy, done;
  logic          in_win, sel;
  logic [CD-1:0] blend;
  logic          unused_bus;

  assign we         = cs & write;
  assign at_origin  = (x == 11'd0) && (y == 11'd0);
  assign fs         = at_origin & ~origin_q;
  assign unused_bus = ^{addr, wr_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) origin_q <= 1'b0;
    else          origin_q <= at_origin;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_mode <= MODE_BYPASS;
      stg_x0   <= '0;
      stg_x1   <= '0;
      stg_y0   <= '0;
      stg_y1   <= '0;
      stg_key  <= '0;
    end else if (we) begin
      case (addr[2:0])
        REG_CTRL: stg_mode <= mode_t'(wr_data[1:0]);
        REG_XWIN: begin
          stg_x0 <= wr_data[10:0];
          stg_x1 <= wr_data[26:16];
        end
        REG_YWIN: begin
          stg_y0 <= wr_data[10:0];
          stg_y1 <= wr_data[26:16];
        end
        REG_KEY:  stg_key <= wr_data[CD-1:0];
        default: ;
      endcase
    end
  end

  // Commit samples the staging copy before any same-cycle write lands in it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_mode <= MODE_BYPASS;
      act_x0   <= '0;
      act_x1   <= '0;
      act_y0   <= '0;
      act_y1   <= '0;
      act_key  <= '0;
    end else if (fs) begin
      act_mode <= stg_mode;
      act_x0   <= stg_x0;
      act_x1   <= stg_x1;
      act_y0   <= stg_y0;
      act_y1   <= stg_y1;
      act_key  <= stg_key;
    end
  end

`ifdef VGA_FADE_EN
  logic       stg_dir, pending;
  logic [7:0] stg_fps;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_dir <= 1'b0;
      stg_fps <= 8'd1;
      pending <= 1'b0;
    end else begin
      if (fs) pending <= 1'b0;
      if (we && addr[2:0] == REG_CTRL) begin
        stg_dir <= wr_data[CTRL_DIR_BIT];
        if (wr_data[CTRL_START_BIT]) pending <= 1'b1;
      end
      if (we && addr[2:0] == REG_FPS) stg_fps <= wr_data[7:0];
    end
  end

  // At every fs the staged fps/dir are exactly the values becoming active.
  vga_fade_ctrl #(.FW(FW)) u_fade (
    .clk     (clk),
    .reset_n (reset_n),
    .fs      (fs),
    .start   (fs & pending),
    .dir     (stg_dir),
    .fps     (stg_fps),
    .level   (lvl),
    .busy    (busy),
    .done    (done)
  );
`else
  assign lvl  = L_MAX;
  assign busy = 1'b0;
  assign done = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    if (addr[2:0] == REG_CTRL) begin
      rd_data[FW:0]        = lvl;
      rd_data[ST_BUSY_BIT] = busy;
      rd_data[ST_DONE_BIT] = done;
    end
  end

  assign in_win = (x >= act_x0) && (x <= act_x1) && (y >= act_y0) && (y <= act_y1);

  always_comb begin
    sel = 1'b0;
    case (act_mode)
      MODE_WIN: sel = in_win;
      MODE_KEY: sel = in_win && (ovl_rgb != act_key);
      default:  sel = 1'b0;
    endcase
  end

  assign inv_lvl = L_MAX - lvl;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [AW-1:0] acc;
    assign acc = AW'(ovl_rgb[c*CW +: CW]) * AW'(lvl) + AW'(si_rgb[c*CW +: CW]) * AW'(inv_lvl);
    assign blend[c*CW +: CW] = CW'(acc >> FW);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) so_rgb <= '0;
    else          so_rgb <= sel ? blend : si_rgb;
  end

endmodule

// File: tb/tb_chu_vga_fade_core.sv
// Bench for chu_vga_fade_core: directed plan scenarios plus randomized frames vs a frame-level model.
module tb_chu_vga_fade_core;

  localparam int CD  = 12;
  localparam int FW  = 4;
  localparam int MAX = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] x, y;
  logic        cs, write;
  logic [13:0] addr;
  logic [31:0] wr_data, rd_data;
  logic [11:0] si_rgb, ovl_rgb, so_rgb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chu_vga_fade_core #(.CD(CD), .FW(FW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y       (y),
    .cs      (cs),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .si_rgb  (si_rgb),
    .ovl_rgb (ovl_rgb),
    .so_rgb  (so_rgb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: staged/active register sets and a frame-count based fade level.
  int s_mode, s_x0, s_x1, s_y0, s_y1, s_key, s_fps, s_dir;
  int a_mode, a_x0, a_x1, a_y0, a_y1, a_key;
  bit pend, prev_org, m_fading, m_done, m_dir;
  int m_lvl, m_n, m_fps;

  function automatic void model_reset();
    s_mode = 0; s_x0 = 0; s_x1 = 0; s_y0 = 0; s_y1 = 0; s_key = 0; s_fps = 1; s_dir = 0;
    a_mode = 0; a_x0 = 0; a_x1 = 0; a_y0 = 0; a_y1 = 0; a_key = 0;
    pend = 0; prev_org = 0; m_fading = 0; m_done = 0; m_dir = 0;
    m_lvl = MAX; m_n = 0; m_fps = 1;
  endfunction

  function automatic int exp_pixel(input int px, input int py, input int si, input int ovl);
    bit inw, sel;
    int r, co, cs_;
    inw = px >= a_x0 && px <= a_x1 && py >= a_y0 && py <= a_y1;
    sel = (a_mode == 1 && inw) || (a_mode == 2 && inw && ovl != a_key);
    if (!sel) return si;
    r = 0;
    for (int c = 0; c < 3; c++) begin
      co  = (ovl >> (4 * c)) & 15;
      cs_ = (si >> (4 * c)) & 15;
      r  |= ((co * m_lvl + cs_ * (MAX - m_lvl)) / MAX) << (4 * c);
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input int ad);
    if (ad != 0) return 32'h0;
    return 32'(m_lvl) | (32'(m_fading) << 8) | (32'(m_done) << 9);
  endfunction

  function automatic void model_step(input int px, input int py, input bit we, input int ad,
                                     input logic [31:0] wd);
    bit org;
    org = (px == 0 && py == 0);
    if (org && !prev_org) begin
      a_mode = s_mode; a_x0 = s_x0; a_x1 = s_x1; a_y0 = s_y0; a_y1 = s_y1; a_key = s_key;
`ifdef VGA_FADE_EN
      if (pend) begin
        m_fading = 1; m_done = 0; m_dir = s_dir[0]; m_n = 0;
        m_fps = (s_fps == 0) ? 1 : s_fps;
        m_lvl = m_dir ? MAX : 0;
      end else if (m_fading) begin
        m_n++;
        m_lvl = m_dir ? MAX - m_n / m_fps : m_n / m_fps;
        if ((!m_dir && m_lvl == MAX) || (m_dir && m_lvl == 0)) begin
          m_fading = 0; m_done = 1;
        end
      end
      pend = 0;
`endif
    end
    prev_org = org;
    if (we) begin
      case (ad)
        0: begin
          s_mode = int'(wd[1:0]);
          s_dir  = int'(wd[3]);
          if (wd[2]) pend = 1;
        end
        1: begin s_x0 = int'(wd[10:0]); s_x1 = int'(wd[26:16]); end
        2: begin s_y0 = int'(wd[10:0]); s_y1 = int'(wd[26:16]); end
        3: s_key = int'(wd[11:0]);
        4: s_fps = int'(wd[7:0]);
        default: ;
      endcase
    end
  endfunction

  // One clk cycle: drive, check rd_data, predict, clock, check so_rgb.
  task automatic cyc(input int px, input int py, input int si, input int ovl,
                     input bit we, input int ad, input logic [31:0] wd, input string tag);
    int e, r;
    x = 11'(px); y = 11'(py); si_rgb = 12'(si); ovl_rgb = 12'(ovl);
    if (we) begin
      cs = 1'b1; write = 1'b1;
    end else begin
      r = $urandom_range(0, 2); cs = (r == 1); write = (r == 2);
    end
    addr = {11'($urandom), 3'(ad)};
    wr_data = wd;
    #1;
    check_eq({tag, "_rd"}, rd_data, exp_rd(ad));
    e = exp_pixel(px, py, si, ovl);
    model_step(px, py, we, ad, wd);
    @(posedge clk); #1;
    check_eq({tag, "_pix"}, 32'(so_rgb), 32'(e));
  endtask

  task automatic wr(input int ad, input logic [31:0] wd);
    cyc(500, 500, $urandom_range(0, 4095), $urandom_range(0, 4095), 1'b1, ad, wd, "wr");
  endtask

  task automatic px(input int xx, input int yy, input int si, input int ovl);
    cyc(xx, yy, si, ovl, 1'b0, 0, 32'h0, "px");
  endtask

  task automatic frame();
    cyc(0, 0, 12'h0, 12'h0, 1'b0, 0, 32'h0, "fs");
    cyc(0, 0, 12'h0, 12'h0, 1'b0, 0, 32'h0, "fs");
    cyc(7, 3, 12'h0, 12'h0, 1'b0, 0, 32'h0, "fs");
  endtask

  task automatic gen_wr(output int ad, output logic [31:0] wd);
    ad = $urandom_range(0, 5);
    wd = $urandom;
    if (ad == 4 && (m_fading || pend)) ad = 3;
    case (ad)
      0: if ($urandom_range(0, 1) == 0) wd[2] = 1'b0;
      1, 2: begin
        wd[10:0]  = 11'($urandom_range(0, 20));
        wd[26:16] = 11'($urandom_range(0, 24));
      end
      3: if ($urandom_range(0, 1) == 0) wd[11:0] = 12'hF0F;
      4: wd[7:0] = 8'($urandom_range(0, 2));
      default: ;
    endcase
  endtask

  initial begin
    int ad, ovl;
    logic [31:0] wd;

    // Reset
    reset_n = 1'b0; x = 11'd5; y = 11'd5; cs = 1'b0; write = 1'b0;
    addr = 14'd0; wr_data = 32'h0; si_rgb = 12'hABC; ovl_rgb = 12'h555;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_so", 32'(so_rgb), 32'h0);
    check_eq("rst_status", rd_data, 32'h10);
    reset_n = 1'b1;
    cyc(5, 5, 12'hABC, 12'h555, 1'b0, 0, 32'h0, "rst_rel");
    check_eq("rst_pass", 32'(so_rgb), 32'hABC);

    // Window commit at frame start
    wr(1, 32'd100 | (32'd199 << 16));
    wr(2, 32'd50 | (32'd99 << 16));
    wr(0, 32'd1);
    px(100, 50, 12'h111, 12'h222);
    check_eq("win_precommit", 32'(so_rgb), 32'h111);
    frame();
    px(100, 50, 12'h111, 12'h222);
    check_eq("win_corner", 32'(so_rgb), 32'h222);
    px(199, 99, 12'h111, 12'h333);
    check_eq("win_far_corner", 32'(so_rgb), 32'h333);
    px(200, 50, 12'h111, 12'h222);
    check_eq("win_x_out", 32'(so_rgb), 32'h111);
    px(100, 100, 12'h111, 12'h222);
    check_eq("win_y_out", 32'(so_rgb), 32'h111);

    // Colour key
    wr(3, 32'hF0F);
    wr(0, 32'd2);
    frame();
    px(150, 60, 12'h456, 12'hF0F);
    check_eq("key_hit", 32'(so_rgb), 32'h456);
    px(150, 60, 12'h456, 12'h123);
    check_eq("key_miss", 32'(so_rgb), 32'h123);

    // Write on the fs cycle commits one frame later
    cyc(0, 0, 0, 0, 1'b1, 0, 32'd0, "coin");
    cyc(7, 3, 0, 0, 1'b0, 0, 32'h0, "coin");
    px(150, 60, 12'h456, 12'h123);
    check_eq("coin_not_yet", 32'(so_rgb), 32'h123);
    frame();
    px(150, 60, 12'h456, 12'h123);
    check_eq("coin_applied", 32'(so_rgb), 32'h456);

`ifdef VGA_FADE_EN
    // Fade-in, fps=2
    wr(4, 32'd2);
    wr(0, 32'd1 | 32'd4);
    check_eq("fade_pre_L", rd_data, 32'h10);
    frame();
    check_eq("fade_start", rd_data, 32'h100);
    for (int k = 1; k <= 32; k++) begin
      frame();
      check_eq("fade_L", 32'(rd_data[4:0]), 32'(k / 2));
    end
    check_eq("fade_end", rd_data, 32'h210);
    // Start written on the fs cycle is consumed by the next fs
    cyc(0, 0, 0, 0, 1'b1, 0, 32'd1 | 32'd4, "fstart");
    cyc(7, 3, 0, 0, 1'b0, 0, 32'h0, "fstart");
    check_eq("fstart_late", rd_data, 32'h210);
    frame();
    check_eq("fstart_commit", rd_data, 32'h100);
    repeat (16) frame();
    check_eq("blend_L8", 32'(rd_data[4:0]), 32'd8);
    px(150, 60, 12'h0F0, 12'hF00);
    check_eq("blend_770", 32'(so_rgb), 32'h770);
    px(150, 60, 12'h000, 12'hFFF);
    check_eq("blend_777", 32'(so_rgb), 32'h777);
    // Fade-out then reset at L=5
    wr(0, 32'd1 | 32'd4 | 32'd8);
    frame();
    check_eq("fout_start", rd_data, 32'h110);
    repeat (22) frame();
    check_eq("fout_L5", rd_data, 32'h105);
`else
    wr(4, 32'd2);
    wr(0, 32'd1 | 32'd4);
    repeat (3) frame();
    check_eq("nofade_L", rd_data, 32'h10);
    px(150, 60, 12'h0F0, 12'hF00);
    check_eq("nofade_opaque", 32'(so_rgb), 32'hF00);
`endif

    // Asynchronous reset mid-operation
    x = 11'd150; y = 11'd60; si_rgb = 12'h321; ovl_rgb = 12'h999; addr = 14'd0;
    cs = 1'b0; write = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_so", 32'(so_rgb), 32'h0);
    check_eq("midrst_status", rd_data, 32'h10);
    @(posedge clk); #1;
    model_reset();
    reset_n = 1'b1;
    px(150, 60, 12'h321, 12'h999);
    check_eq("midrst_bypass", 32'(so_rgb), 32'h321);

    // Randomized frames
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < $urandom_range(1, 3); i++) begin
          gen_wr(ad, wd);
          wr(ad, wd);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        gen_wr(ad, wd);
        cyc(0, 0, $urandom_range(0, 4095), $urandom_range(0, 4095), 1'b1, ad, wd, "rnd_fs");
      end else begin
        cyc(0, 0, $urandom_range(0, 4095), $urandom_range(0, 4095), 1'b0, 0, 32'h0, "rnd_fs");
      end
      for (int p = 0; p < 10; p++) begin
        ovl = ($urandom_range(0, 2) == 0) ? 12'hF0F : $urandom_range(0, 4095);
        cyc($urandom_range(0, 24), $urandom_range(0, 24), $urandom_range(0, 4095), ovl,
            1'b0, $urandom_range(0, 7), 32'h0, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chu_vga_fade_core.md
# chu_vga_fade_core

Parametrised overlay and blend stage for the VGA video slot chain. It merges an overlay stream (`ovl_rgb`, from a generator such as a title or bar source) onto the incoming stream (`si_rgb`) inside a programmable rectangular window, with an optional colour key and a per-channel alpha level. A frame-stepped fade engine ramps the alpha between fully transparent and fully opaque. Programming is via the standard video slot bus; registers are shadowed and committed only at frame start, so on-screen changes never tear mid-frame.

## Interface
Parameters:
- `CD`, 12: colour depth in bits, 3 equal channels; `CW = CD/3`.
- `FW`, 4: fade resolution; alpha level `L` ranges 0..`MAX`, where `MAX = 2**FW`. `L` is `FW+1` bits wide.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  **asynchronous, active-low reset.**
- `x`, `y`  in  11 each  pixel coordinates from the frame counter; held for several `clk` cycles per pixel.
- `cs`, `write`  in  1 each  slot select and write strobe; write enable is `cs & write`.
- `addr`  in  14  register address; only `addr[2:0]` is decoded.
- `wr_data`  in  32  write data.
- `rd_data`  out  32  read data, combinational from `addr`.
- `si_rgb`  in  CD  upstream pixel, aligned with `x`/`y`.
- `ovl_rgb`  in  CD  overlay pixel, aligned with `x`/`y`.
- `so_rgb`  out  CD  downstream pixel.

## Operation
- Register map (writes go to the staging copy):
  - 0 ctrl: [1:0] mode (0 bypass, 1 window overlay, 2 window overlay with colour key, 3 reserved and treated as bypass); [2] fade start, self-clearing, arms a pending flag; [3] fade direction (0 = in, 1 = out).
  - 1 x window: x0 = [10:0], x1 = [26:16].
  - 2 y window: y0 = [10:0], y1 = [26:16].
  - 3 key colour: [CD-1:0].
  - 4 frames per fade step: [7:0]. A value of 0 is treated as 1.
- Read at 0 returns status: [FW:0] = `L`, [8] = busy, [9] = done (sticky; cleared by the next fade start commit). All other addresses read 0.
- Frame start (`fs`) is a one-cycle pulse on the rising edge of `(x==0 && y==0)`, detected with a registered flag.
- On `fs`, all staged registers are copied to the active set and the pending fade start is consumed.
- A write in the same cycle as `fs` is not committed; it takes effect at the following `fs`.
- Window test is inclusive: `x0<=x<=x1 && y0<=y<=y1`. If x0>x1 or y0>y1, the window is empty.
- Overlay select (`sel`):
  - mode 1: `sel` = in window.
  - mode 2: `sel` = in window && `ovl_rgb != key`.
  - otherwise: `sel` = 0.
- Output pixel: if `sel`, per channel `(ovl*L + si*(MAX-L)) >> FW`, truncated; otherwise `si`.
  - At `L=MAX` the output is exactly `ovl`; at `L=0` it is exactly `si`.
  - Intermediate width per channel is `CW+FW+1` bits, with no overflow.
- Fade FSM states IDLE and FADING. `L` resets to `MAX`.
  - IDLE to FADING on a commit with start: load `L` = 0 (in) or `MAX` (out), load the frame divider from fps, set busy, clear done.
  - FADING: each `fs` decrements the divider. When it reaches 0, step `L` by ±1 and reload the divider.
  - On reaching `MAX` (in) or 0 (out): go to IDLE, clear busy, set done.
  - A start commit while FADING restarts from the start level.

## Timing
- `so_rgb` is registered: latency 1 `clk` from `x`/`y`/`si_rgb`/`ovl_rgb`.
- Active-register and `L` changes are visible from the first pixel sampled after the `fs` cycle.
- Values while `reset_n` is low:
  - `so_rgb` = 0, mode = 0, window = 0..0, key = 0, fps = 1.
  - `L` = `MAX`, busy = 0, done = 0, pending = 0, state = IDLE.
  - Asserting reset mid-fade aborts the fade to these values immediately.
- `rd_data` follows `addr` with zero cycles of latency.

## Configuration
- `VGA_FADE_EN` defined: the fade FSM and frame divider are built.
- Not defined:
  - `L` is tied to `MAX`.
  - ctrl bits [3:2] and register 4 are ignored.
  - Status reads `L=MAX`, busy = 0, done = 0.
  - The window and key paths are unchanged.

## Structure
- Package `chu_vga_pkg` holds:
  - mode enum (`MODE_BYPASS`, `MODE_WIN`, `MODE_KEY`, `MODE_RSV`);
  - register address constants;
  - fade state enum (`FADE_IDLE`, `FADE_RUN`);
  - status bit positions.
- One sub-module, `vga_fade_ctrl`: it contains the fade FSM, frame divider and `L` register. Its inputs are `fs`, start, direction and fps; its outputs are `L`, busy and done. It is instantiated only under `VGA_FADE_EN`.

## Test plan
All scenarios use `CD=12`, `FW=4`.
- **Reset:** hold `reset_n` low. Expect `so_rgb`=0, status `L`=16, busy=0. Release with mode 0 and `si_rgb`=0xABC; expect `so_rgb`=0xABC one cycle later.
- **Window and commit:** write mode 1, x 100..199, y 50..99 mid-frame. Expect no change until `fs`. After `fs`: at (100,50) `so_rgb`=`ovl_rgb`; at (200,50) and (100,100) `so_rgb`=`si_rgb`.
- **Colour key:** mode 2, key 0xF0F. `ovl`=0xF0F in window gives `si`; `ovl`=0x123 gives 0x123.
- **Blend arithmetic:** freeze mid fade-in at `L`=8 with `ovl`=0xF00, `si`=0x0F0. Expect 0x770. With `ovl`=0xFFF, `si`=0x000, expect 0x777.
- **Fade-in sequence:** fps=2, start, dir=0. Expect `L`=0 at the committing `fs`, +1 every 2 frames, `L`=16 after 32 frames, then busy=0 and done=1. A write coinciding with `fs` commits one frame later.
- **Reset mid-fade:** assert `reset_n` low at `L`=5. Expect `L`=16, mode 0 and `so_rgb`=0 immediately.
